// File: rtl/pow_iter.sv
// pow_iter: iterative integer power y = a**b with Verilog '**' semantics,
// truncated to WIDTH bits. Non-negative exponents use LSB-first
// square-and-multiply, one exponent bit per cycle. Negative exponents are
// resolved in a single cycle.
//
// Ports:
//   clk    - clock, all state updates on rising edge
//   rst_n  - synchronous active-low reset
//   start  - request, sampled only while ready=1
//   a, b   - base / exponent, captured at acceptance
//   ready  - high iff idle
//   done   - one-cycle pulse, y/undef valid
//   y      - result (0 when undef)
//   undef  - result is x (0 raised to a negative exponent)
module pow_iter #(
    parameter int unsigned WIDTH    = 8,
    parameter bit          A_SIGNED = 1'b1,
    parameter bit          B_SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             undef
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] acc_q;
    logic             neg_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] base_step;
    logic [WIDTH-1:0] res_y;
    logic             res_undef;

    logic             ready_d;
    logic             done_d;
    logic [WIDTH-1:0] y_d;
    logic             undef_d;

    assign accept = (state == IDLE) && start;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            y     <= '0;
            undef <= 1'b0;
        end else begin
            state <= state_d;
            ready <= ready_d;
            done  <= done_d;
            y     <= y_d;
            undef <= undef_d;
        end
    end

    // Next-state logic; a negative exponent needs only one CALC cycle
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (start) state_d = CALC;
            CALC: if (neg_q || (cnt_q == CW'(WIDTH - 1))) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic; result is loaded only on the edge entering DONE
    always_comb begin
        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
        y_d     = y;
        undef_d = undef;
        if ((state == CALC) && (state_d == DONE)) begin
            y_d     = res_y;
            undef_d = res_undef;
        end
    end

    // One square-and-multiply step plus the negative-exponent table
    always_comb begin
        acc_step  = exp_q[0] ? WIDTH'(acc_q * base_q) : acc_q;
        base_step = WIDTH'(base_q * base_q);
        res_y     = acc_step;
        res_undef = 1'b0;
        if (neg_q) begin
            if (base_q == '0) begin
                res_y     = '0;
                res_undef = 1'b1;
            end else if (base_q == ONE) begin
                res_y = ONE;
            end else if (A_SIGNED && (&base_q)) begin
                // base is -1: sign follows exponent parity
                res_y = exp_q[0] ? '1 : ONE;
            end else begin
                res_y = '0;
            end
        end
    end

    // Operand capture and iteration registers
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            base_q <= a;
            exp_q  <= b;
            acc_q  <= ONE;
            neg_q  <= B_SIGNED && b[WIDTH-1];
            cnt_q  <= '0;
        end else if (state == CALC) begin
            acc_q  <= acc_step;
            base_q <= base_step;
            exp_q  <= exp_q >> 1;
            cnt_q  <= cnt_q + CW'(1);
        end
    end
endmodule

// File: tb/tb_pow_iter.sv
// Testbench for pow_iter: 16 instances covering WIDTH {2,5,8,16} x four
// signedness modes. Channel index i: width group i/4, A_SIGNED=(i/2)%2,
// B_SIGNED=i%2. Expected results go to per-channel queues when a request is
// driven and are popped when done is observed.
module tb_pow_iter;
    localparam int NCH   = 16;
    localparam int CH_US = 9;   // WIDTH 8, a unsigned, b signed
    localparam int CH_SU = 10;  // WIDTH 8, a signed,   b unsigned
    localparam int CH_SS = 11;  // WIDTH 8, a signed,   b signed

    typedef struct {
        logic [15:0] y;
        logic        u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v [NCH];
    logic [15:0] a_v     [NCH];
    logic [15:0] b_v     [NCH];
    logic [15:0] y_v     [NCH];
    logic        ready_v [NCH];
    logic        done_v  [NCH];
    logic        undef_v [NCH];
    exp_t        sb      [NCH][$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_dut
        localparam int unsigned W = (gi < 4) ? 2 : (gi < 8) ? 5 : (gi < 12) ? 8 : 16;
        logic [W-1:0] y_w;
        pow_iter #(
            .WIDTH   (W),
            .A_SIGNED(((gi / 2) % 2) == 1),
            .B_SIGNED((gi % 2) == 1)
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .start(start_v[gi]),
            .a    (a_v[gi][W-1:0]),
            .b    (b_v[gi][W-1:0]),
            .ready(ready_v[gi]),
            .done (done_v[gi]),
            .y    (y_w),
            .undef(undef_v[gi])
        );
        assign y_v[gi] = 16'(y_w);
    end

    function automatic int ch_w(input int ch);
        return (ch < 4) ? 2 : (ch < 8) ? 5 : (ch < 12) ? 8 : 16;
    endfunction

    // Reference: language '**' for non-negative exponents, explicit table otherwise
    function automatic exp_t ref_pow(input int ch, input logic [15:0] av, input logic [15:0] bv);
        exp_t        r;
        int          w;
        bit          as;
        bit          bs;
        logic [63:0] mask;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        w    = ch_w(ch);
        as   = ((ch / 2) % 2) == 1;
        bs   = (ch % 2) == 1;
        mask = (64'd1 << w) - 64'd1;
        ua   = {48'd0, av} & mask;
        ub   = {48'd0, bv} & mask;
        r.u  = 1'b0;
        if (!(bs && bv[w-1])) begin
            p   = ua ** ub;
            r.y = 16'(p & mask);
        end else if (ua == 64'd0) begin
            r.y = 16'd0;
            r.u = 1'b1;
        end else if (ua == 64'd1) begin
            r.y = 16'd1;
        end else if (as && (ua == mask)) begin
            r.y = bv[0] ? 16'(mask) : 16'd1;
        end else begin
            r.y = 16'd0;
        end
        return r;
    endfunction

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 7))
            0:       return 16'd0;
            1:       return 16'd1;
            2:       return m;
            3:       return m - 16'd1;
            default: return 16'($urandom) & m;
        endcase
    endfunction

    // Drive one request and wait (bounded) for done; returns edges after acceptance
    task automatic run_req(input int ch, input logic [15:0] av, input logic [15:0] bv,
                           output int lat, output logic [15:0] yo, output logic uo);
        lat = -1;
        yo  = 'x;
        uo  = 1'bx;
        @(negedge clk);
        for (int k = 0; k < 40 && !ready_v[ch]; k++) @(negedge clk);
        start_v[ch] = 1'b1;
        a_v[ch]     = av;
        b_v[ch]     = bv;
        @(posedge clk);
        @(negedge clk);
        start_v[ch] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[ch]) begin
                lat = k;
                yo  = y_v[ch];
                uo  = undef_v[ch];
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
            checks++;
            if ({ready_v[i], done_v[i], y_v[i], undef_v[i]} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset ch%0d: ready=%b done=%b y=%h undef=%b want 1 0 0000 0",
                         i, ready_v[i], done_v[i], y_v[i], undef_v[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nonneg();
        logic [15:0] ta [3] = '{16'h00FE, 16'h0003, 16'h0000};
        logic [15:0] tb [3] = '{16'h0003, 16'h0002, 16'h0000};
        logic [15:0] ty [3] = '{16'h00F8, 16'h0009, 16'h0001};
        exp_t        e;
        int          lat;
        logic [15:0] yo;
        logic        uo;
        for (int i = 0; i < 3; i++) begin
            sb[CH_SS].push_back('{ty[i], 1'b0});
            run_req(CH_SS, ta[i], tb[i], lat, yo, uo);
            e = sb[CH_SS].pop_front();
            checks++;
            if ({yo, uo} !== {e.y, e.u}) begin
                errors++;
                $display("FAIL nonneg[%0d] result: y=%h undef=%b want y=%h undef=%b", i, yo, uo, e.y, e.u);
            end
            checks++;
            if (lat != 8) begin
                errors++;
                $display("FAIL nonneg[%0d] latency: got %0d want 8", i, lat);
            end
            checks++;
            if (ready_v[CH_SS] !== 1'b0) begin
                errors++;
                $display("FAIL nonneg[%0d] ready in done cycle: got %b want 0", i, ready_v[CH_SS]);
            end
            @(negedge clk);
            checks++;
            if ({ready_v[CH_SS], done_v[CH_SS]} !== 2'b10) begin
                errors++;
                $display("FAIL nonneg[%0d] after done: ready=%b done=%b want 1 0", i,
                         ready_v[CH_SS], done_v[CH_SS]);
            end
        end
    endtask

    task automatic test_neg();
        logic [15:0] ta [4] = '{16'h0000, 16'h00FF, 16'h00FF, 16'h0002};
        logic [15:0] tb [4] = '{16'h00FF, 16'h00FD, 16'h00FE, 16'h00FE};
        logic [15:0] ty [4] = '{16'h0000, 16'h00FF, 16'h0001, 16'h0000};
        logic        tu [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_t        e;
        int          lat;
        logic [15:0] yo;
        logic        uo;
        for (int i = 0; i < 4; i++) begin
            sb[CH_SS].push_back('{ty[i], tu[i]});
            run_req(CH_SS, ta[i], tb[i], lat, yo, uo);
            e = sb[CH_SS].pop_front();
            checks++;
            if ({yo, uo} !== {e.y, e.u}) begin
                errors++;
                $display("FAIL neg[%0d] result: y=%h undef=%b want y=%h undef=%b", i, yo, uo, e.y, e.u);
            end
            checks++;
            if (lat != 1) begin
                errors++;
                $display("FAIL neg[%0d] latency: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_mixed_sign();
        int          tc [2] = '{CH_US, CH_SU};
        logic [15:0] ta [2] = '{16'h00FF, 16'h0003};
        logic [15:0] tb [2] = '{16'h00FE, 16'h00FF};
        logic [15:0] ty [2] = '{16'h0000, 16'h00AB};
        int          tl [2] = '{1, 8};
        exp_t        e;
        int          lat;
        logic [15:0] yo;
        logic        uo;
        for (int i = 0; i < 2; i++) begin
            sb[tc[i]].push_back('{ty[i], 1'b0});
            run_req(tc[i], ta[i], tb[i], lat, yo, uo);
            e = sb[tc[i]].pop_front();
            checks++;
            if ({yo, uo} !== {e.y, e.u}) begin
                errors++;
                $display("FAIL mixed[%0d] result: y=%h undef=%b want y=%h undef=%b", i, yo, uo, e.y, e.u);
            end
            checks++;
            if (lat != tl[i]) begin
                errors++;
                $display("FAIL mixed[%0d] latency: got %0d want %0d", i, lat, tl[i]);
            end
        end
    endtask

    task automatic test_reset_abort();
        exp_t        e;
        int          lat;
        int          ndone;
        logic [15:0] yo;
        logic        uo;
        sb[CH_SS].push_back('{16'h0009, 1'b0});
        run_req(CH_SS, 16'h0003, 16'h0002, lat, yo, uo);
        e = sb[CH_SS].pop_front();
        checks++;
        if (yo !== e.y) begin
            errors++;
            $display("FAIL abort_pre y: got %h want %h", yo, e.y);
        end
        @(negedge clk);
        start_v[CH_SS] = 1'b1;
        a_v[CH_SS]     = 16'h00FE;
        b_v[CH_SS]     = 16'h0003;
        @(posedge clk);
        @(negedge clk);
        start_v[CH_SS] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (ready_v[CH_SS] !== 1'b0) begin
            errors++;
            $display("FAIL abort busy: ready=%b want 0", ready_v[CH_SS]);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ready_v[CH_SS], done_v[CH_SS], y_v[CH_SS], undef_v[CH_SS]} !== {1'b1, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort reset: ready=%b done=%b y=%h undef=%b want 1 0 0000 0",
                     ready_v[CH_SS], done_v[CH_SS], y_v[CH_SS], undef_v[CH_SS]);
        end
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[CH_SS]) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort no_done: saw %0d done pulses want 0", ndone);
        end
        // start presented in the very first cycle after reset release
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n          = 1'b1;
        start_v[CH_SS] = 1'b1;
        a_v[CH_SS]     = 16'h0005;
        b_v[CH_SS]     = 16'h0002;
        sb[CH_SS].push_back('{16'h0019, 1'b0});
        @(posedge clk);
        @(negedge clk);
        start_v[CH_SS] = 1'b0;
        checks++;
        if (ready_v[CH_SS] !== 1'b0) begin
            errors++;
            $display("FAIL release accept: ready=%b want 0", ready_v[CH_SS]);
        end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_v[CH_SS]) begin
                lat = k;
                break;
            end
        end
        e = sb[CH_SS].pop_front();
        checks++;
        if ((lat != 8) || (y_v[CH_SS] !== e.y)) begin
            errors++;
            $display("FAIL release result: lat=%0d y=%h want lat=8 y=%h", lat, y_v[CH_SS], e.y);
        end
    endtask

    task automatic test_ignore();
        exp_t        e;
        int          ndone;
        int          lat;
        logic [15:0] ydone;
        logic [15:0] yo;
        logic        uo;
        @(negedge clk);
        start_v[CH_SS] = 1'b1;
        a_v[CH_SS]     = 16'h0003;
        b_v[CH_SS]     = 16'h0005;
        sb[CH_SS].push_back('{16'h00F3, 1'b0});
        @(posedge clk);
        @(negedge clk);
        start_v[CH_SS] = 1'b0;
        ndone = 0;
        ydone = 'x;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            start_v[CH_SS] = 1'b0;
            if (k == 2) begin
                start_v[CH_SS] = 1'b1;
                a_v[CH_SS]     = 16'h0005;
                b_v[CH_SS]     = 16'h0003;
            end
            if (done_v[CH_SS]) begin
                ndone++;
                ydone          = y_v[CH_SS];
                start_v[CH_SS] = 1'b1;
                a_v[CH_SS]     = 16'h0007;
                b_v[CH_SS]     = 16'h0001;
            end
        end
        e = sb[CH_SS].pop_front();
        checks++;
        if (ydone !== e.y) begin
            errors++;
            $display("FAIL ignore result: y=%h want %h", ydone, e.y);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL ignore done_count: got %0d want 1", ndone);
        end
        checks++;
        if (ready_v[CH_SS] !== 1'b1) begin
            errors++;
            $display("FAIL ignore idle: ready=%b want 1", ready_v[CH_SS]);
        end
        sb[CH_SS].push_back('{16'h0080, 1'b0});
        run_req(CH_SS, 16'h0002, 16'h0007, lat, yo, uo);
        e = sb[CH_SS].pop_front();
        checks++;
        if ((yo !== e.y) || (lat != 8)) begin
            errors++;
            $display("FAIL ignore next: y=%h lat=%0d want y=%h lat=8", yo, lat, e.y);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ta [2] = '{16'h0002, 16'h0001};
        logic [15:0] tb [2] = '{16'h0003, 16'h00FF};
        logic [15:0] ty [2] = '{16'h0008, 16'h0001};
        int          tn [2] = '{9, 2};
        exp_t        e;
        int          busy;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            start_v[CH_SS] = 1'b1;
            a_v[CH_SS]     = ta[i];
            b_v[CH_SS]     = tb[i];
            sb[CH_SS].push_back('{ty[i], 1'b0});
            @(posedge clk);
            @(negedge clk);
            start_v[CH_SS] = 1'b0;
            busy = 0;
            for (int k = 0; k < 40; k++) begin
                if (ready_v[CH_SS]) break;
                busy++;
                if (done_v[CH_SS]) begin
                    e = sb[CH_SS].pop_front();
                    checks++;
                    if (y_v[CH_SS] !== e.y) begin
                        errors++;
                        $display("FAIL b2b[%0d] y: got %h want %h", i, y_v[CH_SS], e.y);
                    end
                end
                @(posedge clk);
                @(negedge clk);
            end
            checks++;
            if (busy != tn[i]) begin
                errors++;
                $display("FAIL b2b[%0d] busy_cycles: got %0d want %0d", i, busy, tn[i]);
            end
        end
    endtask

    task automatic test_random(input int per);
        int   issued [NCH];
        int   cyc;
        bit   busy;
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            issued[i] = 0;
            sb[i].delete();
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            busy = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                start_v[i] = 1'b0;
                if (done_v[i]) begin
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL rand ch%0d unexpected done", i);
                    end else begin
                        e = sb[i].pop_front();
                        if ({y_v[i], undef_v[i]} !== {e.y, e.u}) begin
                            errors++;
                            $display("FAIL rand ch%0d: y=%h undef=%b want y=%h undef=%b",
                                     i, y_v[i], undef_v[i], e.y, e.u);
                        end
                    end
                end
                if (ready_v[i] && (issued[i] < per) && ($urandom_range(0, 3) != 0)) begin
                    a_v[i]     = pick(ch_w(i));
                    b_v[i]     = pick(ch_w(i));
                    start_v[i] = 1'b1;
                    sb[i].push_back(ref_pow(i, a_v[i], b_v[i]));
                    issued[i]++;
                end else begin
                    // operand churn while busy must not disturb captured values
                    a_v[i] = 16'($urandom);
                    b_v[i] = 16'($urandom);
                end
                if ((issued[i] < per) || (sb[i].size() != 0)) busy = 1'b1;
            end
        end while (busy && (cyc < 60000));
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL rand timeout after %0d cycles", cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            start_v[i] = 1'b0;
            a_v[i]     = 16'd0;
            b_v[i]     = 16'd0;
        end
        test_reset();
        test_nonneg();
        test_neg();
        test_mixed_sign();
        test_reset_abort();
        test_ignore();
        test_back_to_back();
        test_random(640);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pow_iter.md
POW_ITER -- requirements
Module: pow_iter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: bit width of operands a, b and result y; legal values 2..32.
REQ-002 The module SHALL have parameter A_SIGNED, default 1: 1 = base a is two's-complement, 0 = base a is unsigned.
REQ-003 The module SHALL have parameter B_SIGNED, default 1: 1 = exponent b is two's-complement, 0 = exponent b is unsigned.
REQ-004 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 The module SHALL have port start  input  1  request; sampled only while ready=1.
REQ-007 The module SHALL have port a  input  WIDTH  base operand; captured at acceptance.
REQ-008 The module SHALL have port b  input  WIDTH  exponent operand; captured at acceptance.
REQ-009 The module SHALL have port ready  output  1  high iff in IDLE; request can be accepted.
REQ-010 The module SHALL have port done  output  1  one-cycle pulse; y and undef are valid.
REQ-011 The module SHALL have port y  output  WIDTH  result a**b, truncated modulo 2^WIDTH.
REQ-012 The module SHALL have port undef  output  1  high when the result is x per IEEE 1364-2005 table 5-5; y=0 then.

Function
REQ-013 The module SHALL implement the states IDLE, CALC and DONE; ready=1 only in IDLE, done=1 only in DONE.
REQ-014 The module SHALL accept a request on the acceptance edge, which is a rising edge with start=1, ready=1 and rst_n=1: capture a and b, enter CALC.
REQ-015 The module SHALL ignore start while in CALC or DONE; captured operands stay unchanged, and a/b changes after acceptance have no effect.
REQ-016 The module SHALL treat b as negative only if B_SIGNED=1 and b[WIDTH-1]=1; with B_SIGNED=0, b is always non-negative (0..2^WIDTH-1).
REQ-017 The module SHALL treat a as -1 if A_SIGNED=1 and a=all-ones; with A_SIGNED=0, all-ones a is 2^WIDTH-1 (magnitude >1).
REQ-018 The module SHALL compute a non-negative b by LSB-first square-and-multiply:
- one exponent bit per CALC cycle, exactly WIDTH cycles regardless of b's value;
- all products truncated to WIDTH bits;
- b=0 gives y=1, including 0**0.
REQ-019 The module SHALL resolve a negative b in one CALC cycle:
- a=0: undef=1, y=0;
- a=1: y=1;
- a=-1 (signed only): y=1 if b even, y=all-ones if b odd;
- any other a: y=0.
REQ-020 The module SHALL set undef=0 for every case other than a=0 with negative b.
REQ-021 The module SHALL set latency N = WIDTH CALC cycles for non-negative b and N = 1 for negative b:
- done is high during the cycle after the N-th rising edge following the acceptance edge;
- ready returns high one edge later.
REQ-022 The module SHALL update y and undef only on the edge entering DONE and hold them until the next entry into DONE.
REQ-023 The module SHALL allow a new request on the first cycle ready=1 after done (back-to-back throughput N+2 cycles).

Reset
REQ-024 The module SHALL, on any rising edge with rst_n=0, go to IDLE and set ready=1, done=0, y=0, undef=0.
REQ-025 The module SHALL let reset override start and abort any CALC or DONE in progress, with no done pulse for the aborted request.
REQ-026 The module SHALL, in the first cycle after rst_n returns high, be able to accept start.

Verification
REQ-027 The bench SHALL check (WIDTH=8, A_SIGNED=1, B_SIGNED=1) a=8'hFE (-2), b=3 -> y=8'hF8, undef=0, done 8 edges after acceptance; a=3, b=2 -> y=9; a=0, b=0 -> y=1.
REQ-028 The bench SHALL check (WIDTH=8, A_SIGNED=1, B_SIGNED=1) the negative-b table:
- a=0, b=8'hFF -> undef=1, y=0, done 1 edge after acceptance;
- a=-1, b=-3 -> y=8'hFF;
- a=-1, b=-2 -> y=1;
- a=2, b=-2 -> y=0.
REQ-029 The bench SHALL check (WIDTH=8, A_SIGNED=0, B_SIGNED=1) a=8'hFF, b=8'hFE -> y=0, undef=0; (A_SIGNED=1, B_SIGNED=0) a=3, b=8'hFF -> y=8'hAB after 8 edges.
REQ-030 The bench SHALL check that asserting rst_n=0 during the 4th CALC cycle gives ready=1, done=0, y=0, undef=0 after that edge, and no done follows for the aborted request.
REQ-031 The bench SHALL check that start pulsed with new a/b during CALC and during DONE is ignored: the result matches the originally captured operands, exactly one done is seen, and the next request is accepted when ready=1.
REQ-032 The bench SHALL randomly compare WIDTH in {2,5,8,16} and all four signedness modes against a reference model of REQ-016..REQ-020, over at least 10k requests, including back-to-back starts.
